// File: rtl/tcam_pkg.sv
// Shared types and constants for the pipelined ternary CAM.
// Entry fields are stored at KEY_W_MAX bits; narrower keys are zero-extended on both sides of the compare.
package tcam_pkg;

   localparam int unsigned CNT_W     = 32;
   localparam int unsigned KEY_W_MAX = 144;

   typedef struct packed {
      logic                 valid;
      logic [KEY_W_MAX-1:0] mask;
      logic [KEY_W_MAX-1:0] data;
   } tcam_entry_t;

   function automatic int unsigned miss_addr(input int unsigned tcam_sum);
      return tcam_sum - 1;
   endfunction

endpackage

// File: rtl/tcam_prio_enc.sv
// Log-depth lowest-index priority encoder; reports TCAM_SUM-1 when nothing is set.
module tcam_prio_enc
   import tcam_pkg::*;
#(
   parameter int unsigned TCAM_SUM   = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic [TCAM_SUM-1:0]   match,
   output logic                  hit,
   output logic [ADDR_WIDTH-1:0] idx
);

   localparam int unsigned LEAVES = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] MISS = ADDR_WIDTH'(miss_addr(TCAM_SUM));

   logic [LEAVES-1:0]     h_c;
   logic [ADDR_WIDTH-1:0] ix_c [LEAVES];

   // Pairwise reduction in place: node n of level l+1 overwrites slot n, lower half wins.
   always_comb begin
      h_c = LEAVES'(match);
      for (int n = 0; n < LEAVES; n++) ix_c[n] = ADDR_WIDTH'(n);
      for (int l = 0; l < ADDR_WIDTH; l++) begin
         for (int n = 0; n < (LEAVES >> (l + 1)); n++) begin
            ix_c[n] = h_c[2*n] ? ix_c[2*n] : ix_c[2*n+1];
            h_c[n]  = h_c[2*n] | h_c[2*n+1];
         end
      end
      hit = h_c[0];
      idx = h_c[0] ? ix_c[0] : MISS;
   end

endmodule

// File: rtl/tcam_pipe.sv
// Two-stage pipelined writable ternary CAM with valid/ready lookup handshake.
// Optional lookup/hit statistics counters are built when TCAM_STATS_EN is defined.
module tcam_pipe
   import tcam_pkg::*;
#(
   parameter int unsigned KEY_WIDTH  = 144,
   parameter int unsigned TCAM_SUM   = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef TCAM_STATS_EN
   input  logic                  stat_clr,
   output logic [CNT_W-1:0]      lookup_cnt,
   output logic [CNT_W-1:0]      hit_cnt,
`endif
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [KEY_WIDTH-1:0]  wr_key,
   input  logic [KEY_WIDTH-1:0]  wr_mask,
   input  logic                  wr_valid,
   input  logic [ADDR_WIDTH-1:0] active_num,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [KEY_WIDTH-1:0]  req_key,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_hit,
   output logic [ADDR_WIDTH-1:0] rsp_addr
);

   localparam logic [ADDR_WIDTH-1:0] MISS = ADDR_WIDTH'(miss_addr(TCAM_SUM));

   tcam_entry_t           tbl_q [TCAM_SUM];
   logic [KEY_W_MAX-1:0]  req_key_x, wr_key_x, wr_mask_x;
   logic [TCAM_SUM-1:0]   match_c;
   logic                  out_free_c, accept_c;
   logic                  enc_hit;
   logic [ADDR_WIDTH-1:0] enc_idx;

   logic                  s1_valid_q, s1_valid_d;
   logic [TCAM_SUM-1:0]   s1_vec_q, s1_vec_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_hit_q, rsp_hit_d;
   logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;

   assign req_key_x = KEY_W_MAX'(req_key);
   assign wr_key_x  = KEY_W_MAX'(wr_key);
   assign wr_mask_x = KEY_W_MAX'(wr_mask);

   // Entry storage: only valid bits reset; out-of-range write addresses match no slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TCAM_SUM; i++) tbl_q[i].valid <= 1'b0;
      end else if (wr_en) begin
         for (int i = 0; i < TCAM_SUM; i++) begin
            if (wr_addr == ADDR_WIDTH'(i))
               tbl_q[i] <= '{valid: wr_valid, mask: wr_mask_x, data: wr_key_x};
         end
      end
   end

   always_comb begin
      for (int i = 0; i < TCAM_SUM; i++)
         match_c[i] = tbl_q[i].valid && (ADDR_WIDTH'(i) < active_num) &&
                      (((tbl_q[i].data ^ req_key_x) & ~tbl_q[i].mask) == '0);
   end

   tcam_prio_enc #(
      .TCAM_SUM   (TCAM_SUM),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_enc (
      .match (s1_vec_q),
      .hit   (enc_hit),
      .idx   (enc_idx)
   );

   assign out_free_c = !rsp_valid_q || rsp_ready;
   assign req_ready  = !s1_valid_q || out_free_c;
   assign accept_c   = req_valid && req_ready;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_vec_d    = s1_vec_q;
      rsp_valid_d = rsp_valid_q;
      rsp_hit_d   = rsp_hit_q;
      rsp_addr_d  = rsp_addr_q;
      if (req_ready) begin
         s1_valid_d = accept_c;
         if (accept_c) s1_vec_d = match_c;
      end
      if (out_free_c) begin
         rsp_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            rsp_hit_d  = enc_hit;
            rsp_addr_d = enc_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_vec_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_addr_q  <= MISS;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_vec_q    <= s1_vec_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_hit_q   <= rsp_hit_d;
         rsp_addr_q  <= rsp_addr_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_hit   = rsp_hit_q;
   assign rsp_addr  = rsp_addr_q;

`ifdef TCAM_STATS_EN
   logic [CNT_W-1:0] lookup_cnt_q, lookup_cnt_d;
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

   // Saturating counters; clear takes priority over a same-cycle increment.
   always_comb begin
      lookup_cnt_d = lookup_cnt_q;
      hit_cnt_d    = hit_cnt_q;
      if (stat_clr) begin
         lookup_cnt_d = '0;
         hit_cnt_d    = '0;
      end else begin
         if (accept_c && (lookup_cnt_q != '1))
            lookup_cnt_d = lookup_cnt_q + CNT_W'(1);
         if (rsp_valid_q && rsp_ready && rsp_hit_q && (hit_cnt_q != '1))
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lookup_cnt_q <= '0;
         hit_cnt_q    <= '0;
      end else begin
         lookup_cnt_q <= lookup_cnt_d;
         hit_cnt_q    <= hit_cnt_d;
      end
   end

   assign lookup_cnt = lookup_cnt_q;
   assign hit_cnt    = hit_cnt_q;
`endif

endmodule

// File: tb/tb_tcam_pipe.sv
// Scoreboard bench for tcam_pipe: stimulus pushes expected {hit,addr}, a monitor pops on each response handshake.
module tb_tcam_pipe;

   localparam int unsigned KW = 144;
   localparam int unsigned AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en, wr_valid;
   logic [AW-1:0] wr_addr, active_num;
   logic [KW-1:0] wr_key, wr_mask, req_key;
   logic          req_valid, req_ready;
   logic          rsp_valid, rsp_ready, rsp_hit;
   logic [AW-1:0] rsp_addr;
`ifdef TCAM_STATS_EN
   logic          stat_clr;
   logic [31:0]   lookup_cnt, hit_cnt;
`endif

   int checks = 0;
   int fails  = 0;
   logic [AW:0] exp_q [$];

   always #5 clk = ~clk;

   tcam_pipe #(.KEY_WIDTH(KW), .TCAM_SUM(8), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef TCAM_STATS_EN
      .stat_clr   (stat_clr),
      .lookup_cnt (lookup_cnt),
      .hit_cnt    (hit_cnt),
`endif
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_key     (wr_key),
      .wr_mask    (wr_mask),
      .wr_valid   (wr_valid),
      .active_num (active_num),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_key    (req_key),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_hit    (rsp_hit),
      .rsp_addr   (rsp_addr)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Response monitor.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         logic [AW:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_rsp: got hit=%0d addr=%0d with empty scoreboard", rsp_hit, rsp_addr);
         end else begin
            e = exp_q.pop_front();
            if ({rsp_hit, rsp_addr} !== e) begin
               fails++;
               $display("FAIL rsp: got hit=%0d addr=%0d expected hit=%0d addr=%0d",
                        rsp_hit, rsp_addr, e[AW], e[AW-1:0]);
            end
         end
      end
   end

   task automatic write(input logic [AW-1:0] a, input logic [KW-1:0] k,
                        input logic [KW-1:0] m, input logic v);
      wr_en = 1'b1; wr_addr = a; wr_key = k; wr_mask = m; wr_valid = v;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic lookup(input logic [KW-1:0] k, input logic h, input logic [AW-1:0] a);
      int  cyc;
      logic done;
      cyc = 0; done = 1'b0;
      req_valid = 1'b1; req_key = k;
      while (!done && cyc < 50) begin
         @(negedge clk);
         if (req_ready) begin
            exp_q.push_back({h, a});
            done = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      req_valid = 1'b0;
      if (!done) check("lookup_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   logic [KW-1:0] bp_key [3];
   logic [AW:0]   bp_exp [3];
   logic [KW-1:0] st_key [10];
   logic [AW:0]   st_exp [10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_key = '0; wr_mask = '0;
      active_num = 4'd8; req_valid = 1'b0; req_key = '0; rsp_ready = 1'b1;
`ifdef TCAM_STATS_EN
      stat_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_rsp_hit", 64'(rsp_hit), 64'd0);
      check("reset_rsp_addr", 64'(rsp_addr), 64'd7);
      check("reset_req_ready", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      lookup(144'h0A, 1'b0, 4'd7);
      drain();

      write(4'd2, 144'h0A, 144'h00, 1'b1);
      write(4'd5, 144'h00, 144'h0F, 1'b1);
      lookup(144'h0A, 1'b1, 4'd2);
      active_num = 4'd2;
      lookup(144'h0A, 1'b0, 4'd7);
      active_num = 4'd6;
      lookup(144'h03, 1'b1, 4'd5);
      active_num = 4'd8;
      write(4'd8, 144'h55, 144'h00, 1'b1);
      lookup(144'h55, 1'b0, 4'd7);
      drain();

      // Same-cycle write and lookup, then the lookup again one cycle later.
      wr_en = 1'b1; wr_addr = 4'd1; wr_key = 144'h0A; wr_mask = '0; wr_valid = 1'b1;
      req_valid = 1'b1; req_key = 144'h0A;
      @(negedge clk);
      check("wr_same_cycle_ready", 64'(req_ready), 64'd1);
      exp_q.push_back({1'b1, 4'd2});
      @(posedge clk); #1;
      wr_en = 1'b0;
      @(negedge clk);
      check("wr_next_cycle_ready", 64'(req_ready), 64'd1);
      exp_q.push_back({1'b1, 4'd1});
      @(posedge clk); #1;
      req_valid = 1'b0;
      drain();

      // Backpressure: rsp_ready low for 4 cycles during a 3-deep burst.
      write(4'd1, 144'h0A, 144'h00, 1'b0);
      bp_key[0] = 144'h0A; bp_exp[0] = {1'b1, 4'd2};
      bp_key[1] = 144'h03; bp_exp[1] = {1'b1, 4'd5};
      bp_key[2] = 144'hFF; bp_exp[2] = {1'b0, 4'd7};
      begin
         int n, cyc;
         logic acc;
         n = 0; cyc = 0;
         rsp_ready = 1'b0; req_valid = 1'b1; req_key = bp_key[0];
         while (n < 3 && cyc < 40) begin
            @(negedge clk);
            if (cyc == 2 || cyc == 3) begin
               check("bp_req_ready_low", 64'(req_ready), 64'd0);
               check("bp_rsp_hold_valid", 64'(rsp_valid), 64'd1);
               check("bp_rsp_hold_addr", 64'(rsp_addr), 64'd2);
            end
            acc = req_ready;
            if (acc) exp_q.push_back(bp_exp[n]);
            @(posedge clk); #1;
            if (acc) begin
               n++;
               if (n < 3) req_key = bp_key[n];
               else req_valid = 1'b0;
            end
            cyc++;
            if (cyc == 4) rsp_ready = 1'b1;
         end
         req_valid = 1'b0; rsp_ready = 1'b1;
         check("bp_accepts", 64'(n), 64'd3);
      end
      drain();

      // Last entry hit versus miss share index 7.
      write(4'd7, 144'h77, 144'h00, 1'b1);
      lookup(144'h77, 1'b1, 4'd7);
      drain();

`ifdef TCAM_STATS_EN
      stat_clr = 1'b1;
      @(posedge clk); #1;
      stat_clr = 1'b0;
`endif
      st_key[0] = 144'h0A; st_exp[0] = {1'b1, 4'd2};
      st_key[1] = 144'h03; st_exp[1] = {1'b1, 4'd5};
      st_key[2] = 144'h77; st_exp[2] = {1'b1, 4'd7};
      st_key[3] = 144'hFF; st_exp[3] = {1'b0, 4'd7};
      st_key[4] = 144'h0B; st_exp[4] = {1'b1, 4'd5};
      st_key[5] = 144'h55; st_exp[5] = {1'b0, 4'd7};
      st_key[6] = 144'h00; st_exp[6] = {1'b1, 4'd5};
      st_key[7] = 144'h10; st_exp[7] = {1'b0, 4'd7};
      st_key[8] = 144'h0F; st_exp[8] = {1'b1, 4'd5};
      st_key[9] = 144'h70; st_exp[9] = {1'b0, 4'd7};
      for (int i = 0; i < 10; i++) lookup(st_key[i], st_exp[i][AW], st_exp[i][AW-1:0]);
      drain();
`ifdef TCAM_STATS_EN
      @(negedge clk);
      check("stats_lookup_cnt", 64'(lookup_cnt), 64'd10);
      check("stats_hit_cnt", 64'(hit_cnt), 64'd6);
      @(posedge clk); #1;
      stat_clr = 1'b1;
      lookup(144'hFF, 1'b0, 4'd7);
      stat_clr = 1'b0;
      @(negedge clk);
      check("stats_clr_lookup_cnt", 64'(lookup_cnt), 64'd0);
      check("stats_clr_hit_cnt", 64'(hit_cnt), 64'd0);
      @(posedge clk); #1;
      drain();
`endif

      // active_num boundary.
      write(4'd0, 144'h0A, 144'h00, 1'b1);
      active_num = 4'd0;
      lookup(144'h0A, 1'b0, 4'd7);
      active_num = 4'd1;
      lookup(144'h0A, 1'b1, 4'd0);
      active_num = 4'd8;
      drain();

      // Reset mid-flight discards the lookup and clears all valid bits.
      req_valid = 1'b1; req_key = 144'h0A;
      @(posedge clk); #1;
      req_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rst_flush_rsp_valid", 64'(rsp_valid), 64'd0);
      end
      @(posedge clk); #1;
      lookup(144'h0A, 1'b0, 4'd7);
      lookup(144'h77, 1'b0, 4'd7);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/tcam_pipe.md
# tcam_pipe

Pipelined, writable ternary CAM that generalises the combinational 8-entry lookup into a parametrised depth/width table. It holds its own entry storage with per-entry valid bits. Lookups are accepted through a valid/ready handshake and return the lowest-index matching entry two cycles later, with an explicit hit flag. It sits between the header-field extractor and the action table in the parser.

## Interface
- `KEY_WIDTH`, default 144: key, data and mask width in bits.
- `TCAM_SUM`, default 8: number of entries; any value ≥2, not limited to powers of two.
- `ADDR_WIDTH`, default 3: entry index width; must satisfy 2^ADDR_WIDTH ≥ TCAM_SUM.
- `clk` in 1: single clock; every flop is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write the entry at `wr_addr` this cycle.
- `wr_addr` in ADDR_WIDTH: entry index; writes with `wr_addr` ≥ TCAM_SUM are dropped.
- `wr_key` in KEY_WIDTH: entry data.
- `wr_mask` in KEY_WIDTH: entry mask; bit=1 means don't care.
- `wr_valid` in 1: new valid bit for the entry; 0 invalidates it.
- `active_num` in ADDR_WIDTH: entries with index ≥ `active_num` never match.
- `req_valid` in 1: lookup request.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_key` in KEY_WIDTH: search key.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: downstream accepts the response.
- `rsp_hit` out 1: at least one eligible entry matched.
- `rsp_addr` out ADDR_WIDTH: lowest matching index; TCAM_SUM-1 on a miss.
- `lookup_cnt`, `hit_cnt` out 32 each: present only under `TCAM_STATS_EN`.
- `stat_clr` in 1: present only under `TCAM_STATS_EN`.

## Operation
- Entry i matches when all three hold:
  - `((data[i] ^ key) & ~mask[i]) == 0`
  - `valid[i]`
  - `i < active_num`
- Stage 0 (acceptance cycle): compute the TCAM_SUM-bit match vector combinationally from the current table and `req_key`. Register it into stage 1 with `s1_valid`.
- Stage 1: the priority encoder reduces the vector to the lowest set index plus an any-hit flag. Register these into the output stage (`rsp_valid`, `rsp_hit`, `rsp_addr`).
- Backpressure: the output stage holds while `rsp_valid && !rsp_ready`. Stage 1 advances only if the output stage is empty or being drained.
  - `req_ready = !s1_valid || (output stage empty or draining)`.
  - No bubbles are inserted. Full throughput is one lookup per cycle.
- Write and lookup in the same cycle: the lookup sees the table before the write. The write is visible to lookups accepted from the next cycle on.
- A write to entry i never alters lookups already past stage 0.
- Reset:
  - All entry valid bits = 0; data and mask are not reset.
  - `s1_valid = 0`, `rsp_valid = 0`, `rsp_hit = 0`, `rsp_addr = TCAM_SUM-1`.
  - Asserting `rst` mid-operation discards in-flight lookups.
- `active_num = 0` forces every lookup to miss. Index TCAM_SUM-1 is reported both on a hit of the last entry and on a miss; `rsp_hit` disambiguates.

## Timing
- Request accepted at edge N → `rsp_valid` at edge N+2 when there is no backpressure.
- `req_ready` is combinational from `rsp_ready` and internal valid bits only; it does not depend on `req_valid`.
- `rsp_*` are registered outputs and stay stable while `rsp_valid && !rsp_ready`.
- Table write: one cycle, taking effect at the edge where `wr_en` is sampled.

## Configuration
- `TCAM_STATS_EN` defined:
  - Adds `lookup_cnt` (+1 per accepted request) and `hit_cnt` (+1 per response handshake with `rsp_hit=1`).
  - Both counters are 32-bit and saturate at 0xFFFFFFFF.
  - Both are cleared by `rst` or `stat_clr`; `stat_clr` wins over a same-cycle increment.
- `TCAM_STATS_EN` undefined: the ports, counters and `stat_clr` are absent; zero extra area.

## Structure
- `tcam_pkg`: miss-address default function (TCAM_SUM-1), counter width constant (32), and the entry struct type {valid, mask, data}.
- Sub-module `tcam_prio_enc`:
  - Parametrised on TCAM_SUM and ADDR_WIDTH.
  - Input: match vector. Outputs: `hit` and `idx`.
  - Purely combinational, built as a log-depth tree that generalises the fixed 8→3 encoder.

## Test plan
- Reset, then look up any key → response 2 cycles later with `rsp_hit=0`, `rsp_addr=7` (TCAM_SUM=8).
- Write entry 2 (key=0x0A, mask=0) and entry 5 (key=0x00, mask=0x0F), `active_num=8`, look up 0x0A → `rsp_hit=1`, `rsp_addr=2`.
- Same table with `active_num=2` → lookup 0x0A gives `rsp_hit=0`, `rsp_addr=7`. Lookup 0x03 with `active_num=6` gives `rsp_addr=5`.
- Same cycle: write entry 1 = 0x0A and accept a lookup of 0x0A → `rsp_addr=2`. The same lookup one cycle later → `rsp_addr=1`.
- Issue back-to-back lookups 0x0A, 0x03, 0xFF while holding `rsp_ready=0` for 4 cycles → `req_ready` drops after 2 accepts. Responses appear in order as 2, 5, miss, with no loss or duplication.
- `TCAM_STATS_EN`: 10 lookups, 6 hits → `lookup_cnt=10`, `hit_cnt=6`. Then `stat_clr` plus a concurrent accepted lookup → both counters read 0.
